// File: rtl/qupls_alu_issue_sched_pkg.sv
// rtl/qupls_alu_issue_sched_pkg.sv - ROB sizing constants, index type and scheduler pick record
package QuplsPkg;
    localparam int ROB_ENTRIES = 16;
endpackage

package cpu_types_pkg;
    typedef logic [$clog2(QuplsPkg::ROB_ENTRIES)-1:0] rob_ndx_t;
endpackage

package qupls_alu_issue_sched_pkg;
    import cpu_types_pkg::*;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic     found;
        rob_ndx_t ndx;
    } pick_t;
endpackage

// File: rtl/qupls_oldest_sel.sv
// rtl/qupls_oldest_sel.sv - find the set bit nearest to head walking upward with wrap
module qupls_oldest_sel #(
    parameter int N = 16,
    localparam int NW = $clog2(N)
) (
    input  logic [N-1:0]  vector,
    input  logic [NW-1:0] head,
    output logic [NW-1:0] index,
    output logic          found
);
    logic [NW-1:0] pos;

    // Scan youngest to oldest so the last hit written is the oldest; NW-bit add gives the wrap.
    always_comb begin
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            pos = head + NW'(j);
            if (vector[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end
endmodule

// File: rtl/qupls_alu_issue_sched.sv
// rtl/qupls_alu_issue_sched.sv - age-ordered ALU issue selection from the ROB with registered issue
module qupls_alu_issue_sched
    import cpu_types_pkg::*;
    import qupls_alu_issue_sched_pkg::*;
#(
    parameter int ROB_ENTRIES = QuplsPkg::ROB_ENTRIES,
    parameter int NALU = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  rob_ndx_t               head,
    input  logic [ROB_ENTRIES-1:0] rdy,
    input  logic [ROB_ENTRIES-1:0] alu,
    input  logic [ROB_ENTRIES-1:0] div,
    input  logic                   flush,
    input  logic [ROB_ENTRIES-1:0] flush_mask,
    input  logic [NALU-1:0]        done_v,
    input  rob_ndx_t [NALU-1:0]    done_ndx,
    input  logic [NALU-1:0]        available,
    input  logic [NALU-1:0]        idle,
    output logic [NALU-1:0]        issue,
    output rob_ndx_t [NALU-1:0]    rndx,
    output logic [NALU-1:0]        rndxv,
    output logic [CNT_W-1:0]       issue_cnt
);
    logic [ROB_ENTRIES-1:0] issued;
    logic [ROB_ENTRIES-1:0] cand;
    logic [ROB_ENTRIES-1:0] remain [NALU+1];
    logic [ROB_ENTRIES-1:0] taken  [NALU];
    logic [NALU-1:0]        pick;
    rob_ndx_t [NALU-1:0]    pick_ndx;

    logic [ROB_ENTRIES-1:0] set_mask;
    logic [ROB_ENTRIES-1:0] done_clr;
    logic [ROB_ENTRIES-1:0] issued_next;
    logic [CNT_W-1:0]       n_pick;

    assign cand      = rdy & alu & ~issued;
    assign remain[0] = cand;

    // Station k sees what earlier stations left; only station 0 may take a divide.
    for (genvar k = 0; k < NALU; k++) begin : g_station
        logic [ROB_ENTRIES-1:0] vec;
        pick_t                  sel;

        if (k == 0) begin : g_div_ok
            assign vec = remain[k];
        end else begin : g_no_div
            assign vec = remain[k] & ~div;
        end

        qupls_oldest_sel #(.N(ROB_ENTRIES)) u_oldest_sel (
            .vector (vec),
            .head   (head),
            .index  (sel.ndx),
            .found  (sel.found)
        );

        assign pick[k]       = sel.found & available[k] & idle[k] & ~flush;
        assign pick_ndx[k]   = sel.ndx;
        assign taken[k]      = pick[k] ? (ROB_ENTRIES'(1) << sel.ndx) : '0;
        assign remain[k + 1] = remain[k] & ~taken[k];
    end

    always_comb begin
        set_mask = '0;
        done_clr = '0;
        n_pick   = '0;
        for (int k = 0; k < NALU; k++) begin
            set_mask = set_mask | taken[k];
            if (done_v[k])
                done_clr[done_ndx[k]] = 1'b1;
            n_pick = n_pick + CNT_W'(pick[k]);
        end
    end

    // Set after clear so a same-cycle selection wins over a writeback of that index.
    assign issued_next = (issued & ~done_clr & ~(flush ? flush_mask : '0)) | set_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue     <= '0;
            rndxv     <= '0;
            rndx      <= '0;
            issued    <= '0;
            issue_cnt <= '0;
        end else begin
            issue     <= pick;
            rndxv     <= pick;
            issued    <= issued_next;
            issue_cnt <= issue_cnt + n_pick;
            for (int k = 0; k < NALU; k++) begin
                if (pick[k])
                    rndx[k] <= pick_ndx[k];
            end
        end
    end
endmodule

// File: tb/tb_qupls_alu_issue_sched.sv
// tb/tb_qupls_alu_issue_sched.sv - bench for qupls_alu_issue_sched against an age-scan reference
module tb_qupls_alu_issue_sched;
    import cpu_types_pkg::*;

    localparam int N = 16;

    logic                clk = 1'b0;
    logic                rst;
    rob_ndx_t            head;
    logic [N-1:0]        rdy, alu, div, flush_mask;
    logic                flush;
    logic [1:0]          done_v, available, idle;
    rob_ndx_t [1:0]      done_ndx;
    logic [1:0]          issue, rndxv;
    rob_ndx_t [1:0]      rndx;
    logic [31:0]         issue_cnt;

    int checks = 0;
    int passed = 0;

    bit [N-1:0]          m_issued;
    logic [1:0]          e_issue;
    rob_ndx_t [1:0]      e_rndx;
    logic [31:0]         e_cnt;

    always #5 clk = ~clk;

    qupls_alu_issue_sched #(.ROB_ENTRIES(N), .NALU(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .head       (head),
        .rdy        (rdy),
        .alu        (alu),
        .div        (div),
        .flush      (flush),
        .flush_mask (flush_mask),
        .done_v     (done_v),
        .done_ndx   (done_ndx),
        .available  (available),
        .idle       (idle),
        .issue      (issue),
        .rndx       (rndx),
        .rndxv      (rndxv),
        .issue_cnt  (issue_cnt)
    );

    function automatic int oldest(input logic [N-1:0] v, input int h);
        for (int a = 0; a < N; a++)
            if (v[(h + a) % N]) return (h + a) % N;
        return -1;
    endfunction

    // Predict the effect of the coming edge from the current inputs, then advance past it.
    task automatic tick();
        logic [N-1:0] c;
        int p0, p1;
        if (rst) begin
            m_issued = '0;
            e_issue  = '0;
            e_rndx   = '0;
            e_cnt    = '0;
        end else begin
            c  = rdy & alu & ~m_issued;
            p0 = -1;
            p1 = -1;
            if (!flush && available[0] && idle[0]) p0 = oldest(c, int'(head));
            if (p0 >= 0) c[p0] = 1'b0;
            if (!flush && available[1] && idle[1]) p1 = oldest(c & ~div, int'(head));
            for (int k = 0; k < 2; k++)
                if (done_v[k]) m_issued[done_ndx[k]] = 1'b0;
            if (flush) m_issued = m_issued & ~flush_mask;
            e_issue = {p1 >= 0, p0 >= 0};
            if (p0 >= 0) begin m_issued[p0] = 1'b1; e_rndx[0] = p0[3:0]; end
            if (p1 >= 0) begin m_issued[p1] = 1'b1; e_rndx[1] = p1[3:0]; end
            e_cnt = e_cnt + 32'(p0 >= 0) + 32'(p1 >= 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        head = '0; rdy = '0; alu = '0; div = '0;
        flush = 1'b0; flush_mask = '0; done_v = '0; done_ndx = '0;
        available = 2'b11; idle = 2'b11;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rdy = 16'hffff; alu = 16'hffff;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (issue !== 2'b00) $display("FAIL reset_issue got=%b exp=00", issue); else passed++;
        checks++; if (rndxv !== 2'b00) $display("FAIL reset_rndxv got=%b exp=00", rndxv); else passed++;
        checks++; if (rndx !== '0) $display("FAIL reset_rndx got=%h exp=00", rndx); else passed++;
        checks++; if (issue_cnt !== 32'd0) $display("FAIL reset_cnt got=%0d exp=0", issue_cnt); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        head = 4'd14; rdy = 16'h8002; alu = 16'h8002;
        tick();
        checks++; if (issue !== 2'b11) $display("FAIL wrap_issue got=%b exp=11", issue); else passed++;
        checks++; if (rndx[0] !== 4'd15) $display("FAIL wrap_rndx0 got=%0d exp=15", rndx[0]); else passed++;
        checks++; if (rndx[1] !== 4'd1) $display("FAIL wrap_rndx1 got=%0d exp=1", rndx[1]); else passed++;
        tick();
        checks++; if (issue !== 2'b00) $display("FAIL wrap_pulse got=%b exp=00", issue); else passed++;
    endtask

    task automatic test_div();
        do_reset();
        rdy = 16'h0008; alu = 16'h0008; div = 16'h0008;
        tick();
        checks++; if (issue !== 2'b01) $display("FAIL div_issue got=%b exp=01", issue); else passed++;
        checks++; if (rndx[0] !== 4'd3) $display("FAIL div_rndx0 got=%0d exp=3", rndx[0]); else passed++;
        done_v = 2'b01; done_ndx[0] = 4'd3; idle = 2'b10;
        tick();
        done_v = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (issue !== 2'b00) $display("FAIL div_blocked cycle=%0d got=%b exp=00", i, issue); else passed++;
        end
    endtask

    task automatic test_no_reissue();
        do_reset();
        rdy = 16'h0020; alu = 16'h0020;
        tick();
        checks++; if (issue !== 2'b01 || rndx[0] !== 4'd5) $display("FAIL reissue_first got=%b/%0d exp=01/5", issue, rndx[0]); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (issue !== 2'b00 || rndxv !== 2'b00) $display("FAIL reissue_held cycle=%0d got=%b/%b exp=00/00", i, issue, rndxv); else passed++;
            checks++; if (rndx[0] !== 4'd5) $display("FAIL reissue_rndx_hold got=%0d exp=5", rndx[0]); else passed++;
        end
        done_v = 2'b01; done_ndx[0] = 4'd5;
        tick();
        checks++; if (issue !== 2'b00) $display("FAIL reissue_done_cycle got=%b exp=00", issue); else passed++;
        done_v = 2'b00;
        tick();
        checks++; if (issue !== 2'b01 || rndx[0] !== 4'd5) $display("FAIL reissue_again got=%b/%0d exp=01/5", issue, rndx[0]); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        rdy = 16'h0030; alu = 16'h0030;
        tick();
        checks++; if (issue !== 2'b11 || rndx[0] !== 4'd4 || rndx[1] !== 4'd5) $display("FAIL flush_setup got=%b/%0d/%0d exp=11/4/5", issue, rndx[0], rndx[1]); else passed++;
        rdy = 16'h0070; alu = 16'h0070;
        flush = 1'b1; flush_mask = 16'h0030;
        tick();
        checks++; if (issue !== 2'b00) $display("FAIL flush_issue got=%b exp=00", issue); else passed++;
        flush = 1'b0; flush_mask = '0;
        tick();
        checks++; if (issue !== 2'b11 || rndx[0] !== 4'd4 || rndx[1] !== 4'd5) $display("FAIL flush_cleared got=%b/%0d/%0d exp=11/4/5", issue, rndx[0], rndx[1]); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        rdy = 16'hffff; alu = 16'hffff;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (issue !== 2'b11) $display("FAIL b2b_issue cycle=%0d got=%b exp=11", i, issue); else passed++;
        end
        checks++; if (issue_cnt !== 32'd6) $display("FAIL b2b_cnt got=%0d exp=6", issue_cnt); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (issue !== 2'b00 || issue_cnt !== 32'd0) $display("FAIL b2b_rst got=%b/%0d exp=00/0", issue, issue_cnt); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            head        = 4'($urandom);
            rdy         = 16'($urandom);
            alu         = 16'($urandom) | 16'($urandom);
            div         = 16'($urandom) & 16'($urandom);
            flush       = ($urandom % 8) == 0;
            flush_mask  = 16'($urandom);
            done_v      = 2'($urandom);
            done_ndx[0] = 4'($urandom);
            done_ndx[1] = 4'($urandom);
            available   = ($urandom % 6 == 0) ? 2'($urandom) : 2'b11;
            idle        = 2'($urandom) | 2'($urandom);
            tick();
            checks++; if (issue !== e_issue) $display("FAIL rand_issue cycle=%0d got=%b exp=%b", i, issue, e_issue); else passed++;
            checks++; if (rndxv !== e_issue) $display("FAIL rand_rndxv cycle=%0d got=%b exp=%b", i, rndxv, e_issue); else passed++;
            checks++; if (rndx !== e_rndx) $display("FAIL rand_rndx cycle=%0d got=%h exp=%h", i, rndx, e_rndx); else passed++;
            checks++; if (issue_cnt !== e_cnt) $display("FAIL rand_cnt cycle=%0d got=%0d exp=%0d", i, issue_cnt, e_cnt); else passed++;
        end
    endtask

    initial begin
        quiet_inputs();
        rst = 1'b1;
        test_reset();
        test_wrap();
        test_div();
        test_no_reissue();
        test_flush();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
